subbytes_seq: RTL and testbench
===============================

# subbytes_seq

Parametrised, sequential AES SubBytes/InvSubBytes engine. It substitutes a 128-bit state through LANES S-box lanes per cycle, taking 16/LANES cycles per state, so area can be traded against throughput. Forward or inverse substitution is selected per state. It sits between AddRoundKey and ShiftRows in iterative encrypt/decrypt datapaths and uses valid/ready handshakes on both sides.

## Interface
- LANES, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- BEATS, derived as 16/LANES (not overridable): cycles per state.
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: reset, synchronous and active-low.
- in_valid, input, 1: in_data and in_inv are valid.
- in_ready, output, 1: block can accept a state this cycle.
- in_data, input, 128: state. Byte 0 is [127:120] and byte 15 is [7:0].
- in_inv, input, 1: 0 selects forward S-box (sbox), 1 selects inverse S-box (inv_sbox). Sampled with in_data.
- out_valid, output, 1: out_data holds a completed result.
- out_ready, input, 1: consumer accepts out_data.
- out_data, output, 128: substituted state, same byte order as in_data.
- out_inv, output, 1: in_inv of the state being presented.

## Operation
- Storage:
  - 128-bit working register `st`.
  - 1-bit mode register `inv_q`.
  - Beat counter `cnt`, width max(1, log2(BEATS)).
  - 2-bit state register.
- Datapath:
  - LANES forward sbox instances and LANES inv_sbox instances.
  - Lane k substitutes byte cnt*LANES+k of `st`.
  - `inv_q` muxes forward vs inverse per lane.
  - Results are written back in place into the same byte positions.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid: st<=in_data, inv_q<=in_inv, cnt<=0, go to BUSY.
  - BUSY:
    - in_ready=0, out_valid=0.
    - Each cycle, substitute the LANES bytes selected by cnt.
    - If cnt==BEATS-1, go to DONE; otherwise cnt<=cnt+1.
  - DONE:
    - out_valid=1; out_data=st and out_inv=inv_q, held stable until accepted.
    - On out_ready without in_valid: go to IDLE.
    - On out_ready and in_valid in the same cycle: load the new state and go directly to BUSY (back-to-back). in_ready=out_ready in DONE.
    - While out_ready=0: hold; in_ready=0.
- Each byte is substituted exactly once per accepted state. Bytes not yet reached hold their input value.
- LANES=16: BUSY lasts one cycle and the counter is a constant 0.
- A mode change between states needs no flush; inv_q is reloaded on every accept.

## Timing
- Reset (rst_n=0 sampled at a rising edge):
  - State becomes IDLE; st, inv_q and cnt are cleared.
  - out_valid=0, out_data=0, out_inv=0.
  - in_ready is forced to 0 while rst_n is low and rises in the first cycle after reset is released.
- Reset mid-operation (BUSY or DONE): the in-flight state is discarded with no output. Reset has priority over every handshake in the same cycle.
- Latency:
  - A state accepted at edge t presents out_valid=1 in the cycle after edge t+BEATS.
  - That is 16/LANES cycles after acceptance; LANES=4 gives 4 cycles.
- Throughput:
  - With out_ready held at 1 and in_valid held at 1, one state completes every BEATS+1 cycles: BEATS BUSY cycles plus one DONE cycle that also accepts the next state.
- Handshake rules:
  - A transfer occurs only on valid&&ready at a rising edge.
  - in_valid and in_data are ignored while in_ready=0.
  - out_data and out_inv must not change while out_valid=1 and out_ready=0.
- Output timing: out_valid, in_ready and out_data come from registers or the state only. in_ready in DONE is out_ready, a single gate.

## Test plan
- Forward, LANES=4:
  - Stimulus: in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_inv=0, out_ready=1.
  - Response: out_data=d42711aee0bf98f1b8b45de51e415230 and out_inv=0, 4 cycles after acceptance.
- Inverse, LANES=4:
  - Stimulus: in_data=d42711aee0bf98f1b8b45de51e415230, in_inv=1.
  - Response: out_data=193de3bea0f4e22b9ac68d2ae9f84808 and out_inv=1.
- Parameter sweep, LANES = 1, 2, 8, 16:
  - Stimulus: all-zero state, forward.
  - Response: out_data is 16 bytes of 0x63. Latency is 16, 8, 2 and 1 cycles respectively.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE: out_data stays stable and in_ready=0.
  - Raise out_ready together with in_valid carrying 16 bytes of 0x01, forward: the new state is accepted in that cycle, and the next result is 16 bytes of 0x7c.
- Mode switch:
  - Stimulus: forward state of 16 bytes of 0x53, immediately followed by an inverse state of 16 bytes of 0x63.
  - Response: results are 16 bytes of 0xed, then 16 bytes of 0x00.
- Reset:
  - Stimulus: assert rst_n=0 for one edge during BUSY cycle 2, then release.
  - Response: out_valid never rises for the discarded state, and all outputs are 0. The next accepted state completes correctly.

Source files
------------

// File: rtl/subbytes_seq.sv
// Sequential AES SubBytes / InvSubBytes: a 128-bit state is substituted in place,
// LANES bytes per cycle over BEATS cycles, with valid/ready on both sides.
module subbytes_seq #(
   parameter int LANES = 4,
   localparam int BEATS = 16 / LANES,
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_inv
);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [127:0]    st_q, st_d;
   logic            inv_q, inv_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      lane_in_s  [LANES];
   logic [7:0]      lane_fwd_s [LANES];
   logic [7:0]      lane_inv_s [LANES];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            p = p ^ aa;
         end else begin
            p = p;
         end
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] s;
      s = gf_inv(x);
      return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
   endfunction

   // Per-lane byte pick from the working register and both S-box results.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         lane_in_s[k]  = st_q[8*(15 - (int'(cnt_q)*LANES + k)) +: 8];
         lane_fwd_s[k] = sbox_fwd(lane_in_s[k]);
         lane_inv_s[k] = sbox_inv(lane_in_s[k]);
      end
   end

   // Next-state logic: load on accept, substitute in place while busy, hold until consumed.
   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      inv_d   = inv_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               st_d    = in_data;
               inv_d   = in_inv;
               cnt_d   = {CW{1'b0}};
               state_d = S_BUSY;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            for (int k = 0; k < LANES; k++) begin
               st_d[8*(15 - (int'(cnt_q)*LANES + k)) +: 8] = inv_q ? lane_inv_s[k] : lane_fwd_s[k];
            end
            if (cnt_q == CW'(BEATS - 1)) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  st_d    = in_data;
                  inv_d   = in_inv;
                  cnt_d   = {CW{1'b0}};
                  state_d = S_BUSY;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, working register, mode and beat counter; reset overrides any handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         st_q    <= 128'h0;
         inv_q   <= 1'b0;
         cnt_q   <= {CW{1'b0}};
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         inv_q   <= inv_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
   assign out_valid = (state_q == S_DONE);
   assign out_data  = st_q;
   assign out_inv   = inv_q;

endmodule

// File: tb/tb_subbytes_seq.sv
// Self-checking bench for subbytes_seq: known-answer table, random states against a
// table-based reference, backpressure, back-to-back, mode switch, reset and a LANES sweep.
module tb_subbytes_seq;

   localparam int SW_N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_inv;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         out_inv;

   logic         sw_in_valid;
   logic         sw_out_ready;
   logic [127:0] sw_in_data;
   logic         sw_in_inv;
   logic         sw_in_ready  [SW_N];
   logic         sw_out_valid [SW_N];
   logic [127:0] sw_out_data  [SW_N];
   logic         sw_out_inv   [SW_N];

   int total = 0;
   int bad   = 0;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   typedef struct packed {
      logic [127:0] data;
      logic         inv;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [6];

   // Free-running clock.
   always #5 clk = ~clk;

   subbytes_seq #(.LANES(4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_inv   (in_inv),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_inv  (out_inv)
   );

   for (genvar g = 0; g < SW_N; g++) begin : g_sweep
      localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      subbytes_seq #(.LANES(L)) u_sw (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (sw_in_valid),
         .in_ready (sw_in_ready[g]),
         .in_data  (sw_in_data),
         .in_inv   (sw_in_inv),
         .out_valid(sw_out_valid[g]),
         .out_ready(sw_out_ready),
         .out_data (sw_out_data[g]),
         .out_inv  (sw_out_inv[g])
      );
   end

   function automatic int rotl8(input int v, input int n);
      return ((v << n) | (v >> (8 - n))) & 32'hff;
   endfunction

   // Rijndael S-box built by walking the multiplicative group with generator 3.
   task automatic build_tables();
      int p;
      int q;
      int x;
      p = 1;
      q = 1;
      do begin
         p = (p ^ (p << 1) ^ (((p & 32'h80) != 0) ? 32'h1b : 32'h0)) & 32'hff;
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         q = q & 32'hff;
         if ((q & 32'h80) != 0) q = q ^ 32'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sb[p] = 8'((x ^ 32'h63) & 32'hff);
      end while (p != 1);
      sb[0] = 8'h63;
      for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
   endtask

   function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      for (int b = 0; b < 16; b++) r[8*b +: 8] = inv ? isb[d[8*b +: 8]] : sb[d[8*b +: 8]];
      return r;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [127:0] d, input logic inv);
      int n;
      n = 0;
      in_data  = d;
      in_inv   = inv;
      in_valid = 1'b1;
      while (!in_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 128'(n), 128'(0));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string nm, input logic [127:0] exp_d, input logic exp_i, input int exp_lat);
      int k;
      k = 0;
      while (!out_valid && k < 64) begin
         @(negedge clk);
         k++;
      end
      check({nm, "_lat"}, 128'(k), 128'(exp_lat));
      check({nm, "_data"}, out_data, exp_d);
      check({nm, "_inv"}, {127'd0, out_inv}, {127'd0, exp_i});
   endtask

   // Global time limit so the run always terminates.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Main test sequence.
   initial begin
      logic [127:0] d;
      logic         iv;
      logic [127:0] held;
      logic         seen;
      int           lat [SW_N];
      int           exp_lat [SW_N];
      logic [127:0] got [SW_N];

      build_tables();
      vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
      vecs[1] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
      vecs[2] = '{{16{8'h00}}, 1'b0, {16{8'h63}}};
      vecs[3] = '{{16{8'h01}}, 1'b0, {16{8'h7c}}};
      vecs[4] = '{{16{8'h53}}, 1'b0, {16{8'hed}}};
      vecs[5] = '{{16{8'h63}}, 1'b1, {16{8'h00}}};

      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_data      = 128'h0;
      in_inv       = 1'b0;
      out_ready    = 1'b1;
      sw_in_valid  = 1'b0;
      sw_out_ready = 1'b0;
      sw_in_data   = 128'h0;
      sw_in_inv    = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", {127'd0, in_ready}, 128'd0);
      check("rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_out_inv", {127'd0, out_inv}, 128'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", {127'd0, in_ready}, 128'd1);

      // Known-answer table
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].data, vecs[i].inv);
         wait_result($sformatf("vec%0d", i), vecs[i].exp, vecs[i].inv, 4);
      end

      // Random states against the reference tables
      for (int i = 0; i < 16; i++) begin
         d  = {$urandom, $urandom, $urandom, $urandom};
         iv = 1'($urandom_range(0, 1));
         send(d, iv);
         wait_result($sformatf("rnd%0d", i), ref_sub(d, iv), iv, 4);
      end

      // Backpressure, then back-to-back accept in the releasing cycle
      @(negedge clk);
      out_ready = 1'b0;
      send(vecs[0].data, 1'b0);
      wait_result("bp_first", vecs[0].exp, 1'b0, 4);
      held     = out_data;
      in_data  = {16{8'h01}};
      in_inv   = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp_hold_data%0d", c), out_data, held);
         check($sformatf("bp_hold_ready%0d", c), {127'd0, in_ready}, 128'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", {127'd0, in_ready}, 128'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_busy_valid", {127'd0, out_valid}, 128'd0);
      wait_result("b2b", {16{8'h7c}}, 1'b0, 4);

      // Mode switch with in_valid held high
      @(negedge clk);
      @(negedge clk);
      in_data  = {16{8'h53}};
      in_inv   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_data = {16{8'h63}};
      in_inv  = 1'b1;
      wait_result("mode_fwd", {16{8'hed}}, 1'b0, 4);
      check("mode_ready", {127'd0, in_ready}, 128'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_result("mode_inv", {16{8'h00}}, 1'b1, 4);

      // Reset in the second BUSY cycle discards the state
      @(negedge clk);
      @(negedge clk);
      send(vecs[0].data, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
      check("mid_rst_out_data", out_data, 128'd0);
      check("mid_rst_out_inv", {127'd0, out_inv}, 128'd0);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("mid_rst_no_valid", {127'd0, seen}, 128'd0);
      check("mid_rst_idle_ready", {127'd0, in_ready}, 128'd1);
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'b1);
      wait_result("post_rst", ref_sub(d, 1'b1), 1'b1, 4);

      // LANES sweep: all-zero forward state, latency 16/LANES
      exp_lat = '{16, 8, 2, 1};
      @(negedge clk);
      sw_in_valid = 1'b1;
      for (int g = 0; g < SW_N; g++) check($sformatf("sw%0d_ready", g), {127'd0, sw_in_ready[g]}, 128'd1);
      @(posedge clk);
      @(negedge clk);
      sw_in_valid = 1'b0;
      for (int g = 0; g < SW_N; g++) begin
         lat[g] = -1;
         got[g] = 128'h0;
      end
      for (int k = 0; k < 24; k++) begin
         for (int g = 0; g < SW_N; g++) begin
            if (sw_out_valid[g] && lat[g] < 0) begin
               lat[g] = k;
               got[g] = sw_out_data[g];
            end
         end
         @(negedge clk);
      end
      for (int g = 0; g < SW_N; g++) begin
         check($sformatf("sw%0d_lat", g), 128'(lat[g]), 128'(exp_lat[g]));
         check($sformatf("sw%0d_data", g), got[g], {16{8'h63}});
         check($sformatf("sw%0d_inv", g), {127'd0, sw_out_inv[g]}, 128'd0);
      end
      sw_out_ready = 1'b1;
      @(negedge clk);
      sw_out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
